lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 64*1024*1024, giving the addressable byte count of the attached memory.
REQ-002 SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  1  request offered by the pipeline.
REQ-005 SHALL have port req_ready  output  1  LSU accepts the request this cycle.
REQ-006 SHALL have port req_addr  input  32 (arch_reg)  byte address.
REQ-007 SHALL have port req_wdata  input  32 (arch_reg)  store data, low-aligned.
REQ-008 SHALL have port req_params  input  mem_params_t  read_unsigned, access_size and op of the request.
REQ-009 SHALL have port resp_valid  output  1  response available.
REQ-010 SHALL have port resp_ready  input  1  pipeline takes the response.
REQ-011 SHALL have port resp_rdata  output  32  load result (already extended by memory); 0 for stores and faults.
REQ-012 SHALL have port resp_fault  output  1  request was rejected without a memory access.
REQ-013 SHALL have port mem_address  output  32  to the memory address input.
REQ-014 SHALL have port mem_wdata  output  32  to the memory data_in input.
REQ-015 SHALL have port mem_rdata  input  32  from the memory data_out output (combinational read).
REQ-016 SHALL have port mem_params  output  mem_params_t  to the memory params input.

Function
REQ-017 SHALL implement states IDLE, ACCESS and RESP.
REQ-018 SHALL assert req_ready only in IDLE, or in RESP when resp_ready=1 in the same cycle.
REQ-019 SHALL treat a request as accepted when req_valid and req_ready are both 1; it SHALL latch addr, wdata and params.
REQ-020 SHALL classify an accepted request as faulting when any of the following holds: access_size=RSVD; HALF with addr[0]=1; WORD with addr[1:0]!=0; addr+size > MEM_BYTES.
REQ-021 On a non-faulting accept, SHALL enter ACCESS on the next cycle.
REQ-022 On a faulting accept, SHALL enter RESP directly with resp_fault=1 and no memory access.
REQ-023 In ACCESS (exactly one cycle), SHALL drive mem_address, mem_wdata and mem_params from the latched request; it SHALL capture mem_rdata at the closing edge and then enter RESP.
REQ-024 Outside ACCESS, SHALL drive mem_params.op=MEM_OP_READ, since the memory writes on every cycle it sees op=WRITE; mem_address and mem_wdata SHALL hold their last values.
REQ-025 Latency: for a request accepted at edge N, resp_valid SHALL rise after edge N+2 when non-faulting, and after edge N+1 when faulting.
REQ-026 In RESP, SHALL hold resp_valid=1 with stable rdata and fault until resp_ready=1, then go to IDLE, or to the next request's target state if one is accepted in the same cycle (back-to-back).
REQ-027 A store SHALL produce exactly one memory write cycle and a response with rdata=0 and fault=0.
REQ-028 resp_rdata and resp_fault SHALL be 0 whenever resp_valid=0.

Reset
REQ-029 While reset=0, SHALL force state to IDLE asynchronously and set req_ready=0, resp_valid=0, resp_rdata=0, resp_fault=0, mem_address=0, mem_wdata=0 and mem_params={0,MEM_ACCESS_BYTE,MEM_OP_READ}.
REQ-030 Reset asserted during ACCESS SHALL cancel the write immediately via op=READ; the in-flight request SHALL be dropped with no response.
REQ-031 In the first cycle after reset deasserts, SHALL be in IDLE with req_ready=1.

Structure
REQ-032 mem_op_t, mem_access_size_t, mem_params_t and the memory size constant SHALL live in mem_pkg; lsu_state_t SHALL also be added to mem_pkg.
REQ-033 Fault classification SHALL be a combinational sub-module lsu_align_check (inputs addr and params; output fault).

Verification
REQ-034 Load word addr 0x100 holding 0xDEADBEEF, resp_ready=1 -> resp_valid two cycles after accept, rdata=0xDEADBEEF, fault=0.
REQ-035 Store half 0xA5A5 to 0x202, then load half signed at 0x202 -> exactly one write cycle; load returns 0xFFFFA5A5.
REQ-036 Load word at 0x101 and a store with access_size=RSVD -> each responds one cycle after accept with fault=1; mem_params.op stays READ throughout.
REQ-037 Hold resp_ready=0 for 5 cycles with req_valid=1 continuously -> resp stable, req_ready=0 throughout; on release, the next request is accepted in the handshake cycle.
REQ-038 Assert reset during ACCESS of a store to 0x300 -> memory at 0x300 is unchanged, no response is issued, and all outputs match their REQ-029 reset values.
REQ-039 Load word at MEM_BYTES-2 -> fault=1 with no memory access.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared memory-interface types: op, access size, params bundle and LSU states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_pkg;

    localparam int unsigned MEM_SIZE_BYTES = 64 * 1024 * 1024;

    typedef enum logic {
        MEM_OP_READ  = 1'b0,
        MEM_OP_WRITE = 1'b1
    } mem_op_t;

    typedef enum logic [1:0] {
        MEM_ACCESS_BYTE = 2'd0,
        MEM_ACCESS_HALF = 2'd1,
        MEM_ACCESS_WORD = 2'd2,
        MEM_ACCESS_RSVD = 2'd3
    } mem_access_size_t;

    typedef struct packed {
        logic             read_unsigned;
        mem_access_size_t access_size;
        mem_op_t          op;
    } mem_params_t;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'd0,
        LSU_ACCESS = 2'd1,
        LSU_RESP   = 2'd2
    } lsu_state_t;

    // Number of bytes touched by an access; RSVD touches nothing.
    function automatic logic [2:0] access_bytes(input mem_access_size_t size);
        case (size)
            MEM_ACCESS_BYTE: access_bytes = 3'd1;
            MEM_ACCESS_HALF: access_bytes = 3'd2;
            MEM_ACCESS_WORD: access_bytes = 3'd4;
            default:         access_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align_check.sv
// Flags requests that must not reach memory: reserved size, misalignment, out of range.
// Latency: purely combinational.
// Backpressure: none; evaluated on whatever request is presented.
module lsu_align_check
    import mem_pkg::*;
#(
    parameter int unsigned MEM_BYTES = MEM_SIZE_BYTES
) (
    input  logic [31:0] addr,
    input  mem_params_t params,
    output logic        fault
);

    logic [32:0] end_addr;
    logic        misaligned;
    logic        unused_params;

    // Only the size matters for classification; direction and signedness do not.
    assign unused_params = ^{params.read_unsigned, params.op};

    // One bit of headroom so addresses near 2^32 cannot wrap into range.
    always_comb begin
        end_addr   = {1'b0, addr} + {30'd0, access_bytes(params.access_size)};
        misaligned = 1'b0;
        case (params.access_size)
            MEM_ACCESS_HALF: misaligned = addr[0];
            MEM_ACCESS_WORD: misaligned = |addr[1:0];
            MEM_ACCESS_RSVD: misaligned = 1'b1;
            default:         misaligned = 1'b0;
        endcase
        fault = misaligned || (end_addr > 33'(MEM_BYTES));
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request at a time, one memory cycle per good access.
// Latency: response valid 2 cycles after accept (1 cycle for faulting requests).
// Backpressure: response held until resp_ready; new request accepted in the handshake cycle.
module lsu
    import mem_pkg::*;
#(
    parameter int unsigned MEM_BYTES = MEM_SIZE_BYTES
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  mem_params_t req_params,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output mem_params_t mem_params
);

    lsu_state_t  state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    mem_params_t params_q;
    logic        fault_q;
    logic        req_fault;
    logic        accept;

    lsu_align_check #(
        .MEM_BYTES(MEM_BYTES)
    ) u_align (
        .addr  (req_addr),
        .params(req_params),
        .fault (req_fault)
    );

    // Ready while idle, or while the current response is being taken; never in reset.
    assign req_ready  = reset && ((state == LSU_IDLE) || ((state == LSU_RESP) && resp_ready));
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state == LSU_RESP);
    assign resp_rdata = resp_valid ? rdata_q : 32'd0;
    assign resp_fault = resp_valid && fault_q;

    // The memory writes whenever it sees WRITE, so the op is forced to READ outside
    // ACCESS; because state resets asynchronously this also kills a write mid-cycle.
    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;
    always_comb begin
        mem_params = params_q;
        if (state != LSU_ACCESS) begin
            mem_params.op = MEM_OP_READ;
        end
    end

    // Request/response sequencing; memory-side registers only load on a good request
    // so faulting requests leave the memory port exactly as it was.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= LSU_IDLE;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            fault_q  <= 1'b0;
            params_q <= '{read_unsigned: 1'b0, access_size: MEM_ACCESS_BYTE, op: MEM_OP_READ};
        end else begin
            case (state)
                LSU_IDLE, LSU_RESP: begin
                    if (accept) begin
                        if (req_fault) begin
                            state   <= LSU_RESP;
                            rdata_q <= 32'd0;
                            fault_q <= 1'b1;
                        end else begin
                            state    <= LSU_ACCESS;
                            addr_q   <= req_addr;
                            wdata_q  <= req_wdata;
                            params_q <= req_params;
                            fault_q  <= 1'b0;
                        end
                    end else if ((state == LSU_RESP) && resp_ready) begin
                        state <= LSU_IDLE;
                    end
                end
                LSU_ACCESS: begin
                    state   <= LSU_RESP;
                    rdata_q <= (params_q.op == MEM_OP_READ) ? mem_rdata : 32'd0;
                end
                default: state <= LSU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: behavioural memory plus request-level reference model.
// Latency: n/a.
// Backpressure: randomised resp_ready and held requests.
module tb_lsu;
    import mem_pkg::*;

    localparam int unsigned MB = MEM_SIZE_BYTES;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    mem_params_t req_params;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    mem_params_t mem_params;

    lsu #(.MEM_BYTES(MB)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_params (req_params),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault),
        .mem_address(mem_address),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_params (mem_params)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, {31'd0, act}, {31'd0, exp});
    endtask

    // ---------------- attached memory (environment) ----------------
    logic [7:0] mem_arr[int unsigned];
    logic [7:0] shadow[int unsigned];
    int mem_gen    = 0;
    int mem_writes = 0;

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic int nbytes(input mem_access_size_t s);
        case (s)
            MEM_ACCESS_BYTE: return 1;
            MEM_ACCESS_HALF: return 2;
            MEM_ACCESS_WORD: return 4;
            default:         return 0;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] raw, input int n, input logic uns);
        case (n)
            1: return uns ? {24'd0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            2: return uns ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            4: return raw;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] env_read(input logic [31:0] a, input mem_params_t p);
        logic [31:0] raw;
        logic [31:0] k;
        int n;
        raw = 32'd0;
        n = nbytes(p.access_size);
        for (int i = 0; i < n; i++) begin
            k = a + 32'(i);
            raw[8*i +: 8] = mem_arr.exists(k) ? mem_arr[k] : init_byte(k);
        end
        return extend(raw, n, p.read_unsigned);
    endfunction

    function automatic logic [31:0] shadow_load(input logic [31:0] a, input int n, input logic uns);
        logic [31:0] raw;
        logic [31:0] k;
        raw = 32'd0;
        for (int i = 0; i < n; i++) begin
            k = a + 32'(i);
            raw[8*i +: 8] = shadow.exists(k) ? shadow[k] : init_byte(k);
        end
        return extend(raw, n, uns);
    endfunction

    task automatic put_word(input logic [31:0] a, input logic [31:0] v);
        for (int i = 0; i < 4; i++) begin
            mem_arr[a + 32'(i)] = v[8*i +: 8];
            shadow[a + 32'(i)]  = v[8*i +: 8];
        end
        mem_gen++;
    endtask

    // Combinational read port; refreshed every negedge as well as on input change.
    always @(negedge clock or mem_address or mem_params or mem_gen)
        mem_rdata = env_read(mem_address, mem_params);

    // Memory writes on every rising edge where it sees op=WRITE.
    initial forever begin
        @(posedge clock);
        if (mem_params.op == MEM_OP_WRITE) begin
            for (int i = 0; i < nbytes(mem_params.access_size); i++)
                mem_arr[mem_address + 32'(i)] = mem_wdata[8*i +: 8];
            mem_writes++;
            mem_gen++;
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        int               acc;
        logic             is_wr;
        logic             fault;
        logic [31:0]      addr;
        logic [31:0]      wdata;
        logic [31:0]      rdata;
        mem_access_size_t sz;
    } exp_t;

    exp_t exp_q[$];
    int   cyc        = 0;
    int   exp_writes = 0;
    bit   head_seen  = 0;

    // Single compare process: checks every output against the model each cycle.
    initial forever begin
        exp_t h;
        exp_t e;
        logic exp_rdy;
        logic exp_write;
        int   n;
        @(negedge clock);
        cyc++;
        if (!reset) begin
            check1("rst_req_ready", req_ready, 1'b0);
            check1("rst_resp_valid", resp_valid, 1'b0);
            check("rst_resp_rdata", resp_rdata, 32'd0);
            check1("rst_resp_fault", resp_fault, 1'b0);
            check("rst_mem_address", mem_address, 32'd0);
            check("rst_mem_wdata", mem_wdata, 32'd0);
            check("rst_mem_params", {28'd0, mem_params}, 32'd0);
            exp_q.delete();
            head_seen = 0;
        end else begin
            exp_rdy   = 1'b1;
            exp_write = 1'b0;
            if (exp_q.size() > 0) begin
                h = exp_q[0];
                exp_rdy   = (cyc >= h.acc + (h.fault ? 1 : 2)) && resp_ready;
                exp_write = h.is_wr && !h.fault && (cyc == h.acc + 1);
            end
            check1("req_ready", req_ready, exp_rdy);
            check1("mem_write_cycle", mem_params.op == MEM_OP_WRITE, exp_write);
            if (exp_write) begin
                check("mem_address", mem_address, h.addr);
                check("mem_wdata", mem_wdata, h.wdata);
                check("mem_size", {30'd0, mem_params.access_size}, {30'd0, h.sz});
            end
            if (resp_valid) begin
                check("resp_outstanding", 32'(exp_q.size()), 32'd1);
                if (exp_q.size() > 0) begin
                    h = exp_q[0];
                    if (!head_seen) begin
                        check("resp_latency", 32'(cyc - h.acc), h.fault ? 32'd1 : 32'd2);
                        head_seen = 1;
                    end
                    check("resp_rdata", resp_rdata, h.rdata);
                    check1("resp_fault", resp_fault, h.fault);
                    if (resp_ready) begin
                        if (h.is_wr && !h.fault) begin
                            for (int i = 0; i < nbytes(h.sz); i++)
                                shadow[h.addr + 32'(i)] = h.wdata[8*i +: 8];
                            exp_writes++;
                        end
                        void'(exp_q.pop_front());
                        head_seen = 0;
                    end
                end
            end else begin
                check("idle_rdata", resp_rdata, 32'd0);
                check1("idle_fault", resp_fault, 1'b0);
            end
            if (req_valid && req_ready) begin
                n       = nbytes(req_params.access_size);
                e.acc   = cyc;
                e.addr  = req_addr;
                e.wdata = req_wdata;
                e.sz    = req_params.access_size;
                e.is_wr = (req_params.op == MEM_OP_WRITE);
                e.fault = (n == 0) || (n == 2 && req_addr[0]) || (n == 4 && req_addr[1:0] != 2'b00)
                          || ({32'd0, req_addr} + 64'(n) > 64'(MB));
                e.rdata = (e.fault || e.is_wr) ? 32'd0
                          : shadow_load(req_addr, n, req_params.read_unsigned);
                exp_q.push_back(e);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] w, input mem_op_t op,
                         input mem_access_size_t sz, input logic uns);
        req_addr                 = a;
        req_wdata                = w;
        req_params.op            = op;
        req_params.access_size   = sz;
        req_params.read_unsigned = uns;
    endtask

    task automatic wait_accept();
        bit ok;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clock);
            if (req_ready) ok = 1;
        end
        check1("accept_wait", ok, 1'b1);
    endtask

    task automatic do_req(input logic [31:0] a, input logic [31:0] w, input mem_op_t op,
                          input mem_access_size_t sz, input logic uns,
                          output logic [31:0] rd, output logic flt, output int lat);
        bit got;
        tick();
        drive(a, w, op, sz, uns);
        req_valid  = 1'b1;
        resp_ready = 1'b1;
        wait_accept();
        tick();
        req_valid = 1'b0;
        got = 0; lat = 0; rd = 32'd0; flt = 1'b0;
        for (int i = 1; i <= 20 && !got; i++) begin
            @(negedge clock);
            if (resp_valid) begin
                got = 1; lat = i; rd = resp_rdata; flt = resp_fault;
            end
        end
        check1("resp_wait", got, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        flt;
        int          lat;
        int          w0;
        bit          got;
        bit          rnd_acc;
        int          pick;

        req_valid  = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_params = '{read_unsigned: 1'b0, access_size: MEM_ACCESS_BYTE, op: MEM_OP_READ};
        resp_ready = 1'b0;
        put_word(32'h100, 32'hDEADBEEF);
        put_word(32'h300, 32'hCAFEF00D);

        repeat (3) @(posedge clock);
        #3 reset = 1'b1;
        @(negedge clock);
        check1("post_reset_ready", req_ready, 1'b1);

        // Aligned word load.
        do_req(32'h100, 32'd0, MEM_OP_READ, MEM_ACCESS_WORD, 1'b0, rd, flt, lat);
        check("lw_rdata", rd, 32'hDEADBEEF);
        check1("lw_fault", flt, 1'b0);
        check("lw_latency", 32'(lat), 32'd2);

        // Half store then signed half load.
        w0 = mem_writes;
        do_req(32'h202, 32'h0000A5A5, MEM_OP_WRITE, MEM_ACCESS_HALF, 1'b0, rd, flt, lat);
        check("sh_rdata", rd, 32'd0);
        check1("sh_fault", flt, 1'b0);
        check("sh_write_count", 32'(mem_writes - w0), 32'd1);
        do_req(32'h202, 32'd0, MEM_OP_READ, MEM_ACCESS_HALF, 1'b0, rd, flt, lat);
        check("lh_rdata", rd, 32'hFFFFA5A5);

        // Faulting requests never touch memory.
        w0 = mem_writes;
        do_req(32'h101, 32'd0, MEM_OP_READ, MEM_ACCESS_WORD, 1'b0, rd, flt, lat);
        check1("lw_misalign_fault", flt, 1'b1);
        check("lw_misalign_latency", 32'(lat), 32'd1);
        check("lw_misalign_rdata", rd, 32'd0);
        do_req(32'h40, 32'h12345678, MEM_OP_WRITE, MEM_ACCESS_RSVD, 1'b0, rd, flt, lat);
        check1("rsvd_fault", flt, 1'b1);
        check("rsvd_latency", 32'(lat), 32'd1);
        do_req(MB - 32'd2, 32'd0, MEM_OP_READ, MEM_ACCESS_WORD, 1'b0, rd, flt, lat);
        check1("top_fault", flt, 1'b1);
        check("top_latency", 32'(lat), 32'd1);
        check("fault_write_count", 32'(mem_writes - w0), 32'd0);

        // Stall the response with a second request held behind it.
        tick();
        resp_ready = 1'b0;
        drive(32'h100, 32'd0, MEM_OP_READ, MEM_ACCESS_WORD, 1'b0);
        req_valid = 1'b1;
        wait_accept();
        tick();
        drive(32'h200, 32'd0, MEM_OP_READ, MEM_ACCESS_WORD, 1'b1);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            got = resp_valid;
        end
        check1("stall_resp_seen", got, 1'b1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clock);
            check1("stall_req_ready", req_ready, 1'b0);
            check1("stall_resp_valid", resp_valid, 1'b1);
            check("stall_rdata", resp_rdata, 32'hDEADBEEF);
        end
        tick();
        resp_ready = 1'b1;
        @(negedge clock);
        check1("release_accept", req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
        repeat (4) @(negedge clock);

        // Reset in the middle of a store's memory cycle.
        tick();
        w0 = mem_writes;
        drive(32'h300, 32'h11223344, MEM_OP_WRITE, MEM_ACCESS_WORD, 1'b0);
        req_valid  = 1'b1;
        resp_ready = 1'b1;
        wait_accept();
        @(posedge clock);
        #2 reset = 1'b0;
        req_valid = 1'b0;
        #1;
        check1("rst_kill_op", mem_params.op == MEM_OP_WRITE, 1'b0);
        check1("rst_kill_valid", resp_valid, 1'b0);
        repeat (2) @(posedge clock);
        #3 reset = 1'b1;
        @(negedge clock);
        check1("rst_release_ready", req_ready, 1'b1);
        check1("rst_no_resp", resp_valid, 1'b0);
        check("rst_no_write", 32'(mem_writes - w0), 32'd0);
        do_req(32'h300, 32'd0, MEM_OP_READ, MEM_ACCESS_WORD, 1'b0, rd, flt, lat);
        check("rst_mem_unchanged", rd, 32'hCAFEF00D);

        // Randomised traffic with random response backpressure.
        rnd_acc = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (req_valid && rnd_acc) req_valid = 1'b0;
            if (!req_valid && $urandom_range(0, 3) != 0) begin
                pick = $urandom_range(0, 9);
                if (pick == 0)      req_addr = MB - 32'($urandom_range(1, 8));
                else if (pick == 1) req_addr = 32'hFFFF_FFFF - 32'($urandom_range(0, 7));
                else                req_addr = 32'h200 + 32'($urandom_range(0, 63));
                req_wdata                = $urandom;
                req_params.access_size   = mem_access_size_t'($urandom_range(0, 3));
                req_params.op            = mem_op_t'($urandom_range(0, 1));
                req_params.read_unsigned = 1'($urandom_range(0, 1));
                req_valid = 1'b1;
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clock);
            rnd_acc = req_valid && req_ready;
        end
        tick();
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        repeat (10) @(negedge clock);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        check("write_count", 32'(mem_writes), 32'(exp_writes));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
